// File: rtl/string_hasher_pkg.sv
// Shared types and constants for the string hasher: FSM states, mode encodings, pipeline depth.
package string_hasher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam logic MODE_WINDOW = 1'b0;
    localparam logic MODE_HORNER = 1'b1;
    localparam int   PIPE_LAT    = 2;

endpackage

// File: rtl/sh_adder_tree.sv
// Sums N packed DATA_W lanes (wrapping mod 2^DATA_W) into a registered result.
// Latency 1 cycle; no backpressure, the sum only updates on vld_i and holds otherwise.
module sh_adder_tree #(
    parameter int DATA_W = 32,
    parameter int N      = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  vld_i,
    input  logic [N*DATA_W-1:0]   dat_i,
    output logic                  vld_o,
    output logic [DATA_W-1:0]     sum_o
);

    logic [DATA_W-1:0] sum_d;
    logic [DATA_W-1:0] sum_q;
    logic              vld_q;

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N; i++) begin
            sum_d = sum_d + dat_i[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= 1'b0;
            sum_q <= '0;
        end else begin
            vld_q <= vld_i;
            if (vld_i) begin
                sum_q <= sum_d;
            end
        end
    end

    assign vld_o = vld_q;
    assign sum_o = sum_q;

endmodule

// File: rtl/string_hasher_n.sv
// Streaming hasher: weighted window sum over a TAPS delay line (mode 0) or rolling Horner hash (mode 1).
// Latency: out_valid 2 cycles after the accepting edge; no backpressure, in_valid is taken whenever in FILL/ACTIVE.
module string_hasher_n
    import string_hasher_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAPS   = 4,
    parameter int ITER_W = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    output logic                   done,
    input  logic                   mode,
    input  logic [ITER_W-1:0]      iterations,
    input  logic [TAPS*DATA_W-1:0] weights,
    input  logic                   in_valid,
    input  logic [DATA_W-1:0]      in_data,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data
);

    localparam int FILL_W = $clog2(TAPS);

    state_e                 state_q, state_d;
    logic                   mode_q, mode_d;
    logic [ITER_W-1:0]      iter_q, iter_d;
    logic [ITER_W-1:0]      cnt_q, cnt_d;
    logic [FILL_W-1:0]      fill_q, fill_d;
    logic [DATA_W-1:0]      tap_q [TAPS];
    logic [DATA_W-1:0]      tap_d [TAPS];
    logic [DATA_W-1:0]      h_q, h_d;
    logic [DATA_W-1:0]      w [TAPS];
    logic                   take;
    logic                   produce;
    logic [PIPE_LAT-1:0]    pipe_vld_q;
    logic [TAPS*DATA_W-1:0] prod_q;

    always_comb begin
        for (int i = 0; i < TAPS; i++) begin
            w[i] = weights[i*DATA_W +: DATA_W];
        end
    end

    assign take    = in_valid && (state_q == ST_FILL || state_q == ST_ACTIVE);
    assign produce = in_valid && (state_q == ST_ACTIVE);
    assign done    = (state_q == ST_IDLE);

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        iter_d  = iter_q;
        cnt_d   = cnt_q;
        fill_d  = fill_q;
        tap_d   = tap_q;
        h_d     = h_q;

        if (take) begin
            tap_d[0] = in_data;
            for (int i = 1; i < TAPS; i++) begin
                tap_d[i] = tap_q[i-1];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (run && iterations != '0) begin
                    mode_d = mode;
                    iter_d = iterations;
                    cnt_d  = '0;
                    fill_d = '0;
                    for (int i = 0; i < TAPS; i++) begin
                        tap_d[i] = '0;
                    end
                    // Horner accumulator is seeded from w[1]; window mode leaves it cleared.
                    h_d     = (mode == MODE_HORNER) ? w[1] : '0;
                    state_d = (mode == MODE_HORNER) ? ST_ACTIVE : ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_valid) begin
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_q == FILL_W'(TAPS - 2)) begin
                        state_d = ST_ACTIVE;
                    end
                end
            end
            ST_ACTIVE: begin
                if (in_valid) begin
                    cnt_d = cnt_q + ITER_W'(1);
                    if (mode_q == MODE_HORNER) begin
                        h_d = h_q * w[0] + in_data;
                    end
                    if (cnt_q == iter_q - ITER_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave once the last strobe is on the output and nothing remains behind it.
                if (out_valid && pipe_vld_q == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mode_q     <= MODE_WINDOW;
            iter_q     <= '0;
            cnt_q      <= '0;
            fill_q     <= '0;
            h_q        <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < TAPS; i++) begin
                tap_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            iter_q     <= iter_d;
            cnt_q      <= cnt_d;
            fill_q     <= fill_d;
            h_q        <= h_d;
            tap_q      <= tap_d;
            pipe_vld_q <= {pipe_vld_q[PIPE_LAT-2:0], produce};
        end
    end

    // Product stage reads the post-shift taps / updated accumulator one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (pipe_vld_q[0]) begin
            for (int i = 0; i < TAPS; i++) begin
                if (mode_q == MODE_HORNER) begin
                    prod_q[i*DATA_W +: DATA_W] <= (i == 0) ? h_q : '0;
                end else begin
                    prod_q[i*DATA_W +: DATA_W] <= w[i] * tap_q[i];
                end
            end
        end
    end

    sh_adder_tree #(
        .DATA_W (DATA_W),
        .N      (TAPS)
    ) u_tree (
        .clk_i  (clk),
        .rst_i  (rst),
        .vld_i  (pipe_vld_q[PIPE_LAT-1]),
        .dat_i  (prod_q),
        .vld_o  (out_valid),
        .sum_o  (out_data)
    );

endmodule

// File: tb/tb_string_hasher_n.sv
// Self-checking bench for string_hasher_n with TAPS=4, DATA_W=32 and a queue-based reference model.
module tb_string_hasher_n;

    localparam int DATA_W = 32;
    localparam int TAPS   = 4;
    localparam int ITER_W = 10;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   run;
    logic                   done;
    logic                   mode;
    logic [ITER_W-1:0]      iterations;
    logic [TAPS*DATA_W-1:0] weights;
    logic                   in_valid;
    logic [DATA_W-1:0]      in_data;
    logic                   out_valid;
    logic [DATA_W-1:0]      out_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int done_rise_cyc = 0;
    logic done_prev = 1'b0;

    logic [DATA_W-1:0] wv [TAPS];
    logic [DATA_W-1:0] xs [$];
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] got_dat [$];
    int                got_cyc [$];
    int                acc_cyc [$];

    string_hasher_n #(
        .DATA_W (DATA_W),
        .TAPS   (TAPS),
        .ITER_W (ITER_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .done       (done),
        .mode       (mode),
        .iterations (iterations),
        .weights    (weights),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_data   (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            got_dat.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        if (done === 1'b1 && done_prev !== 1'b1) done_rise_cyc = cyc;
        done_prev = done;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit, got cycle %0d exp completion", cyc);
        $fatal(1, "watchdog");
    end

    // Reference: window sum over the last TAPS inputs, or h = h*w0 + x seeded with w1.
    function automatic void build_model(input logic m, input int iters);
        logic [DATA_W-1:0] s;
        logic [DATA_W-1:0] h;
        exp_q.delete();
        h = wv[1];
        for (int j = 0; j < iters; j++) begin
            if (m == 1'b0) begin
                s = '0;
                for (int i = 0; i < TAPS; i++) s = s + wv[i] * xs[TAPS-1+j-i];
                exp_q.push_back(s);
            end else begin
                h = h * wv[0] + xs[j];
                exp_q.push_back(h);
            end
        end
    endfunction

    task automatic run_job(input logic m, input int iters, input int gap,
                           input bit repulse, input int n_extra, input string tag);
        int n_prod;
        int n_tot;
        int ng;
        int t;
        int pi;
        n_prod = (m == 1'b1) ? iters : TAPS - 1 + iters;
        n_tot  = n_prod + n_extra;
        for (int i = 0; i < TAPS; i++) weights[i*DATA_W +: DATA_W] = wv[i];
        mode = m;
        iterations = ITER_W'(iters);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        mode = ~m;
        iterations = '1;
        got_dat.delete();
        got_cyc.delete();
        acc_cyc.delete();
        tests++;
        if (done !== 1'b0) begin
            fails++;
            $display("FAIL %s done_after_run got %b exp 0", tag, done);
        end
        for (int n = 0; n < n_tot; n++) begin
            in_valid = 1'b1;
            in_data  = xs[n];
            @(negedge clk);
            acc_cyc.push_back(cyc);
            in_valid = 1'b0;
            in_data  = $urandom;
            ng = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int g = 0; g < ng; g++) begin
                run = repulse && n == 1 && g == 0;
                @(negedge clk);
                run = 1'b0;
            end
        end
        t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        tests++;
        if (done !== 1'b1) begin
            fails++;
            $display("FAIL %s done_timeout got %b exp 1", tag, done);
        end
        repeat (4) @(negedge clk);
        tests++;
        if (got_dat.size() != iters) begin
            fails++;
            $display("FAIL %s strobe_count got %0d exp %0d", tag, got_dat.size(), iters);
        end
        for (int j = 0; j < iters && j < got_dat.size(); j++) begin
            pi = (m == 1'b1) ? j : TAPS - 1 + j;
            tests++;
            if (got_dat[j] !== exp_q[j]) begin
                fails++;
                $display("FAIL %s data[%0d] got %0d exp %0d", tag, j, got_dat[j], exp_q[j]);
            end
            tests++;
            if (got_cyc[j] - acc_cyc[pi] != 2) begin
                fails++;
                $display("FAIL %s latency[%0d] got %0d exp 2", tag, j, got_cyc[j] - acc_cyc[pi]);
            end
        end
        if (iters > 0 && got_cyc.size() > 0) begin
            tests++;
            if (done_rise_cyc != got_cyc[got_cyc.size()-1] + 1) begin
                fails++;
                $display("FAIL %s done_rise got cycle %0d exp %0d", tag, done_rise_cyc,
                         got_cyc[got_cyc.size()-1] + 1);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL reset_done got %b exp 1", done); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        tests++;
        if (out_data !== '0) begin fails++; $display("FAIL reset_out_data got %0d exp 0", out_data); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_window_1234();
        wv[0] = 1; wv[1] = 2; wv[2] = 3; wv[3] = 4;
        xs.delete();
        for (int i = 1; i <= 7; i++) xs.push_back(DATA_W'(i));
        exp_q.delete();
        exp_q.push_back(20);
        exp_q.push_back(30);
    endtask

    task automatic test_window_basic();
        set_window_1234();
        run_job(1'b0, 2, 0, 1'b0, 2, "window_basic");
    endtask

    task automatic test_horner_basic();
        wv[0] = 31; wv[1] = 0; wv[2] = 0; wv[3] = 0;
        xs.delete();
        xs.push_back(97);
        xs.push_back(98);
        exp_q.delete();
        exp_q.push_back(97);
        exp_q.push_back(3105);
        run_job(1'b1, 2, 0, 1'b0, 0, "horner_basic");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < TAPS; i++) wv[i] = 32'h8000_0000;
        xs.delete();
        for (int i = 0; i < 4; i++) xs.push_back(2);
        exp_q.delete();
        exp_q.push_back(0);
        run_job(1'b0, 1, 0, 1'b0, 0, "wrap");
    endtask

    task automatic test_gaps_run();
        set_window_1234();
        run_job(1'b0, 2, 3, 1'b1, 2, "gaps_run");
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < TAPS; i++) wv[i] = $urandom;
        for (int i = 0; i < TAPS; i++) weights[i*DATA_W +: DATA_W] = wv[i];
        mode = 1'b0;
        iterations = 5;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int n = 0; n < 5; n++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        got_dat.delete();
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (done !== 1'b1) begin fails++; $display("FAIL rst_mid_done got %b exp 1", done); end
        tests++;
        if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got %b exp 0", out_valid); end
        repeat (6) @(negedge clk);
        tests++;
        if (got_dat.size() != 0) begin
            fails++;
            $display("FAIL rst_mid_stray_strobes got %0d exp 0", got_dat.size());
        end
        for (int i = 0; i < TAPS; i++) wv[i] = $urandom;
        xs.delete();
        for (int i = 0; i < 3; i++) xs.push_back($urandom);
        build_model(1'b1, 3);
        run_job(1'b1, 3, 0, 1'b0, 0, "after_rst");
    endtask

    task automatic test_zero_iter();
        int lows;
        lows = 0;
        mode = 1'b0;
        iterations = '0;
        got_dat.delete();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (done !== 1'b1) lows++;
            in_valid = 1'b1;
            in_data  = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b0;
        tests++;
        if (lows != 0) begin fails++; $display("FAIL zero_iter_done_low got %0d cycles exp 0", lows); end
        tests++;
        if (got_dat.size() != 0) begin
            fails++;
            $display("FAIL zero_iter_strobes got %0d exp 0", got_dat.size());
        end
    endtask

    task automatic test_random();
        logic m;
        int   iters;
        for (int k = 0; k < 8; k++) begin
            m = 1'($urandom_range(0, 1));
            iters = $urandom_range(1, 6);
            for (int i = 0; i < TAPS; i++) wv[i] = $urandom;
            xs.delete();
            for (int i = 0; i < TAPS + iters + 2; i++) xs.push_back($urandom);
            build_model(m, iters);
            run_job(m, iters, -1, 1'b0, 1, "random");
        end
    endtask

    initial begin
        rst        = 1'b1;
        run        = 1'b0;
        mode       = 1'b0;
        iterations = '0;
        weights    = '0;
        in_valid   = 1'b0;
        in_data    = '0;
        test_reset();
        test_window_basic();
        test_horner_basic();
        test_wrap();
        test_gaps_run();
        test_reset_mid();
        test_zero_iter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
